// File: rtl/button_pkg.sv
// button_pkg
//   Shared types and helpers for the push-button event arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, LOCK)
//   - lowest_one  : one-hot select of the lowest set bit (channel 0 wins)
//   - cnt_width   : bit width needed to hold the values 0..max_val
package button_pkg;

  // Widest request vector the priority helper handles.
  localparam int MAX_CH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // v & -v isolates the least significant set bit.
  function automatic logic [MAX_CH-1:0] lowest_one(input logic [MAX_CH-1:0] v);
    return v & (~v + MAX_CH'(1));
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge
//   Synchronises one raw active-low button line into clk and flags its
//   press (synchronised 1->0 transition).
//   Ports:
//     clk      in   system clock
//     rst      in   asynchronous reset, active-low
//     btn_n    in   raw button level, 0 = pressed, asynchronous to clk
//     level_n  out  synchronised button level, 0 = pressed
//     press    out  high for one cycle on a synchronised press
module btn_sync_edge
  import button_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   edge_reg;

  // Both the chain and the edge register reset to "released", so a button
  // already held down when reset lifts still produces one press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '1;
      edge_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_n};
      edge_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level_n = sync_reg[SYNC_STAGES-1];
  assign press   = edge_reg & ~level_n;

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//   Turns N_CH raw active-low buttons into at most one registered one-cycle
//   press pulse per clock, fixed priority (channel 0 highest), followed by a
//   lockout window. Masked channels auto-repeat while held.
//   Ports:
//     clk        in   system clock
//     rst        in   asynchronous reset, active-low
//     btn_n      in   raw button levels, 0 = pressed
//     rpt_en     in   global auto-repeat enable (ANDed with REPEAT_MASK)
//     pulse      out  one-hot-or-zero event, high for one cycle
//     pulse_rpt  out  high together with pulse when the event is a repeat
//     busy       out  high while lockout is active
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int              N_CH          = 3,
  parameter int              SYNC_STAGES   = 2,
  parameter int              LOCKOUT       = 15,
  parameter int              REPEAT_DELAY  = 1000,
  parameter int              REPEAT_PERIOD = 250,
  parameter logic [N_CH-1:0] REPEAT_MASK   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_n,
  input  logic            rpt_en,
  output logic [N_CH-1:0] pulse,
  output logic            pulse_rpt,
  output logic            busy
);

  localparam int LOCK_W  = cnt_width(LOCKOUT);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = cnt_width(RPT_MAX);

  localparam logic [LOCK_W-1:0] LOCK_LOAD   = LOCK_W'(LOCKOUT);
  localparam logic [RPT_W-1:0]  DELAY_LOAD  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0]  PERIOD_LOAD = RPT_W'(REPEAT_PERIOD);

  logic [N_CH-1:0] level_n;
  logic [N_CH-1:0] press_req;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    btn_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .rst    (rst),
      .btn_n  (btn_n[gi]),
      .level_n(level_n[gi]),
      .press  (press_req[gi])
    );
  end

  arb_state_t        state_reg,     state_next;
  logic [LOCK_W-1:0] lock_cnt_reg,  lock_cnt_next;
  logic [RPT_W-1:0]  rpt_cnt_reg,   rpt_cnt_next;
  logic [N_CH-1:0]   held_ch_reg,   held_ch_next;
  logic [N_CH-1:0]   pulse_reg,     pulse_next;
  logic              pulse_rpt_reg, pulse_rpt_next;

  logic [N_CH-1:0] mask_eff;
  logic [N_CH-1:0] press_grant;
  logic            press_any;
  logic            held_low;
  logic            rpt_due;
  logic            take_press;
  logic            take_rpt;

  assign mask_eff    = REPEAT_MASK & {N_CH{rpt_en}};
  assign press_any   = |press_req;
  assign press_grant = N_CH'(lowest_one(MAX_CH'(press_req)));
  assign held_low    = |(held_ch_reg & ~level_n);

  // The pulse is registered, so the repeat is granted in the cycle the
  // counter is about to reach zero; the event then lands exactly
  // REPEAT_DELAY / REPEAT_PERIOD cycles after the previous pulse. A counter
  // that has already saturated at zero (blocked by lockout) stays due.
  assign rpt_due    = (|(held_ch_reg & mask_eff)) && held_low && (rpt_cnt_reg <= RPT_W'(1));
  assign take_press = (state_reg == IDLE) && press_any;
  assign take_rpt   = (state_reg == IDLE) && !press_any && rpt_due;

  // State register (holds all block state)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      lock_cnt_reg  <= '0;
      rpt_cnt_reg   <= '0;
      held_ch_reg   <= '0;
      pulse_reg     <= '0;
      pulse_rpt_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lock_cnt_reg  <= lock_cnt_next;
      rpt_cnt_reg   <= rpt_cnt_next;
      held_ch_reg   <= held_ch_next;
      pulse_reg     <= pulse_next;
      pulse_rpt_reg <= pulse_rpt_next;
    end
  end

  // Next-state: FSM with lockout counter, plus the repeat tracker
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    held_ch_next  = held_ch_reg;
    rpt_cnt_next  = rpt_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (take_press || take_rpt) begin
          state_next    = LOCK;
          lock_cnt_next = LOCK_LOAD;
        end
      end
      LOCK: begin
        // Requests seen here are simply dropped, never queued.
        if (lock_cnt_reg <= LOCK_W'(1)) begin
          state_next    = IDLE;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt_reg - LOCK_W'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        lock_cnt_next = '0;
      end
    endcase

    if (take_press) begin
      // A fresh press always takes over the held record.
      held_ch_next = press_grant;
      rpt_cnt_next = (|(press_grant & mask_eff)) ? DELAY_LOAD : '0;
    end else if (take_rpt) begin
      rpt_cnt_next = PERIOD_LOAD;
    end else if ((held_ch_reg != '0) && (!held_low || !rpt_en)) begin
      held_ch_next = '0;
      rpt_cnt_next = '0;
    end else if ((held_ch_reg != '0) && (rpt_cnt_reg != '0)) begin
      rpt_cnt_next = rpt_cnt_reg - RPT_W'(1);
    end
  end

  // Output decode
  always_comb begin
    pulse_next     = '0;
    pulse_rpt_next = 1'b0;
    if (take_press) begin
      pulse_next = press_grant;
    end else if (take_rpt) begin
      pulse_next     = held_ch_reg;
      pulse_rpt_next = 1'b1;
    end
  end

  assign pulse     = pulse_reg;
  assign pulse_rpt = pulse_rpt_reg;
  assign busy      = (state_reg == LOCK);

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter
//   Directed bench for button_event_arbiter with N_CH=3, SYNC_STAGES=2,
//   LOCKOUT=15, REPEAT_DELAY=40, REPEAT_PERIOD=10, REPEAT_MASK=3'b011.
//   Cycle 0 is the cycle in which the stimulus is applied; the outputs of
//   cycle n are sampled 1 ns after the n-th following rising edge.
module tb_button_event_arbiter;

  localparam int LOG_N = 256;

  logic       clk;
  logic       rst;
  logic [2:0] btn_n;
  logic       rpt_en;
  logic [2:0] pulse;
  logic       pulse_rpt;
  logic       busy;

  int vec_cnt;
  int miscompare_cnt;
  int cyc;

  logic [2:0] pulse_log [0:LOG_N-1];
  logic       rpt_log   [0:LOG_N-1];
  logic       busy_log  [0:LOG_N-1];

  button_event_arbiter #(
    .N_CH         (3),
    .SYNC_STAGES  (2),
    .LOCKOUT      (15),
    .REPEAT_DELAY (40),
    .REPEAT_PERIOD(10),
    .REPEAT_MASK  (3'b011)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .rpt_en   (rpt_en),
    .pulse    (pulse),
    .pulse_rpt(pulse_rpt),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_scn();
    cyc = 0;
    for (int i = 0; i < LOG_N; i++) begin
      pulse_log[i] = '0;
      rpt_log[i]   = 1'b0;
      busy_log[i]  = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < LOG_N) begin
      pulse_log[cyc] = pulse;
      rpt_log[cyc]   = pulse_rpt;
      busy_log[cyc]  = busy;
    end
  endtask

  function automatic int count_pulses(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (pulse_log[i] != 3'b000) n++;
    return n;
  endfunction

  function automatic int count_rpt(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (rpt_log[i]) n++;
    return n;
  endfunction

  function automatic int count_busy(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (busy_log[i]) n++;
    return n;
  endfunction

  initial begin
    vec_cnt        = 0;
    miscompare_cnt = 0;
    cyc            = 0;
    rst            = 1'b0;
    btn_n          = 3'b111;
    rpt_en         = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pulse", 32'(pulse), 32'h0);
    check_eq("rst_pulse_rpt", 32'(pulse_rpt), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    start_scn();
    repeat (5) tick();
    check_eq("idle_no_pulse", 32'(count_pulses(1, 5)), 32'd0);
    $display("reset: outputs idle");

    // Single tap on channel 1
    start_scn();
    btn_n = 3'b101;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (cyc == 5) btn_n = 3'b111;
    end
    check_eq("tap_pulse_c3", 32'(pulse_log[3]), 32'h2);
    check_eq("tap_pulse_count", 32'(count_pulses(1, 30)), 32'd1);
    check_eq("tap_rpt_count", 32'(count_rpt(1, 30)), 32'd0);
    check_eq("tap_busy_c2", 32'(busy_log[2]), 32'h0);
    check_eq("tap_busy_c3", 32'(busy_log[3]), 32'h1);
    check_eq("tap_busy_c17", 32'(busy_log[17]), 32'h1);
    check_eq("tap_busy_c18", 32'(busy_log[18]), 32'h0);
    check_eq("tap_busy_len", 32'(count_busy(1, 30)), 32'd15);
    $display("single tap ch1: pulse@3=%b busy cycles=%0d", pulse_log[3], count_busy(1, 30));

    // Simultaneous press on channels 0 and 2
    start_scn();
    btn_n = 3'b010;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (cyc == 5) btn_n = 3'b111;
    end
    check_eq("simul_pulse_c3", 32'(pulse_log[3]), 32'h1);
    check_eq("simul_pulse_count", 32'(count_pulses(1, 30)), 32'd1);
    $display("simultaneous ch0+ch2: pulse@3=%b", pulse_log[3]);

    // Bouncing channel 0 inside the lockout window
    start_scn();
    btn_n = 3'b110;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (cyc == 2 || cyc == 6 || cyc == 10) btn_n[0] = 1'b1;
      else if (cyc == 4 || cyc == 8) btn_n[0] = 1'b0;
    end
    check_eq("bounce_pulse_c3", 32'(pulse_log[3]), 32'h1);
    check_eq("bounce_pulse_count", 32'(count_pulses(1, 40)), 32'd1);
    $display("bounce ch0: pulses=%0d", count_pulses(1, 40));

    // Auto-repeat on channel 0 held for 100 cycles
    rpt_en = 1'b1;
    start_scn();
    btn_n = 3'b110;
    for (int c = 1; c <= 130; c++) begin
      tick();
      if (cyc == 100) btn_n = 3'b111;
    end
    check_eq("rpt_press_c3", 32'(pulse_log[3]), 32'h1);
    check_eq("rpt_press_flag_c3", 32'(rpt_log[3]), 32'h0);
    check_eq("rpt_first_c43", 32'(pulse_log[43]), 32'h1);
    check_eq("rpt_flag_c43", 32'(rpt_log[43]), 32'h1);
    check_eq("rpt_c59", 32'({rpt_log[59], pulse_log[59]}), 32'h9);
    check_eq("rpt_c75", 32'({rpt_log[75], pulse_log[75]}), 32'h9);
    check_eq("rpt_c91", 32'({rpt_log[91], pulse_log[91]}), 32'h9);
    check_eq("rpt_pulse_count", 32'(count_pulses(1, 130)), 32'd5);
    check_eq("rpt_flag_count", 32'(count_rpt(1, 130)), 32'd4);
    $display("auto-repeat ch0: pulses=%0d repeats=%0d", count_pulses(1, 130), count_rpt(1, 130));

    // Channel 2 held: mask bit clear, no repeats
    start_scn();
    btn_n = 3'b011;
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (cyc == 60) btn_n = 3'b111;
    end
    check_eq("norpt_pulse_c3", 32'(pulse_log[3]), 32'h4);
    check_eq("norpt_pulse_count", 32'(count_pulses(1, 70)), 32'd1);
    check_eq("norpt_flag_count", 32'(count_rpt(1, 70)), 32'd0);
    $display("hold ch2 (unmasked): pulses=%0d", count_pulses(1, 70));

    // Repeat preemption: tap channel 1 while channel 0 repeats; the
    // ch1 press lands in the same cycle a ch0 repeat would (59) and wins.
    start_scn();
    btn_n = 3'b110;
    for (int c = 1; c <= 130; c++) begin
      tick();
      if (cyc == 56) btn_n[1] = 1'b0;
      else if (cyc == 61) btn_n[1] = 1'b1;
      else if (cyc == 120) btn_n[0] = 1'b1;
    end
    check_eq("pre_rpt_c43", 32'({rpt_log[43], pulse_log[43]}), 32'h9);
    check_eq("pre_pulse_c59", 32'(pulse_log[59]), 32'h2);
    check_eq("pre_flag_c59", 32'(rpt_log[59]), 32'h0);
    check_eq("pre_after_count", 32'(count_pulses(60, 130)), 32'd0);
    $display("preemption: pulse@59=%b rpt=%b later pulses=%0d",
             pulse_log[59], rpt_log[59], count_pulses(60, 130));

    // Reset asserted during lockout, button still held through release
    rpt_en = 1'b0;
    start_scn();
    btn_n = 3'b110;
    for (int c = 1; c <= 10; c++) tick();
    check_eq("rstl_pulse_c3", 32'(pulse_log[3]), 32'h1);
    check_eq("rstl_busy_c10", 32'(busy_log[10]), 32'h1);
    rst = 1'b0;
    #1;
    check_eq("rstl_busy_drop", 32'(busy), 32'h0);
    check_eq("rstl_pulse_drop", 32'(pulse), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start_scn();
    for (int c = 1; c <= 30; c++) tick();
    check_eq("rstl_no_pulse_c1", 32'(pulse_log[1]), 32'h0);
    check_eq("rstl_repress_c3", 32'(pulse_log[3]), 32'h1);
    check_eq("rstl_repress_count", 32'(count_pulses(1, 30)), 32'd1);
    btn_n = 3'b111;
    $display("reset in lockout: re-press pulse@3=%b", pulse_log[3]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Parametrised successor to the three-button debounced input stage. It takes N_CH raw active-low push-button lines and produces at most one registered single-cycle press pulse per clock, with fixed priority (channel 0 highest). A programmable lockout window follows every pulse, and channels selected by a mask can auto-repeat while held. It sits between the board button pins and the game-control FSM, which consumes one-hot move pulses (left / right / put and any added controls).

## Interface
- N_CH, 3: number of button channels; 1..16.
- SYNC_STAGES, 2: synchroniser flops per channel; at least 2.
- LOCKOUT, 15: cycles after any pulse during which no pulse is issued; at least 1.
- REPEAT_DELAY, 1000: cycles from a granted press to the first auto-repeat; at least 1.
- REPEAT_PERIOD, 250: cycles between subsequent auto-repeats; at least 1.
- REPEAT_MASK, '0: N_CH-bit mask; bit i enables auto-repeat on channel i.
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- btn_n  in  N_CH  raw button levels; 0 = pressed. Asynchronous to clk.
- rpt_en  in  1  run-time global enable for auto-repeat (ANDed with REPEAT_MASK).
- pulse  out  N_CH  one-hot-or-zero registered event, high for one cycle.
- pulse_rpt  out  1  high with pulse when the event is an auto-repeat.
- busy  out  1  high while lockout is active.

## Operation
- Per channel:
  - The synchroniser chain resets to 1 (released).
  - The edge register resets to 1.
  - A press request is a synchronised 1→0 transition.
  - A button held low through reset release yields exactly one press request.
- FSM states:
  - IDLE: any press request grants the lowest-index requesting channel. The block drives pulse, loads the lockout counter with LOCKOUT and goes to LOCK.
  - LOCK: the counter decrements each cycle. At 1 it returns to IDLE. All press requests arriving in LOCK are discarded, not queued.
- Grant bookkeeping:
  - The granted channel is recorded as held_ch.
  - If its REPEAT_MASK bit is set, the repeat counter is loaded with REPEAT_DELAY.
- Repeat counter:
  - Decrements every cycle while held_ch stays synchronised-low and rpt_en = 1.
  - Saturates at 0.
  - Release of held_ch or rpt_en = 0 clears the held record and the counter.
- Repeat grant:
  - Occurs in IDLE when the repeat counter is 0 and no press request is present.
  - Drives pulse[held_ch] with pulse_rpt = 1, reloads the counter with REPEAT_PERIOD and enters LOCK.
- Simultaneous events:
  - A press request always beats a pending repeat.
  - A new press grant on another channel replaces held_ch.
  - Multiple simultaneous presses: only the lowest index pulses; the others are lost.
- Counter widths: lockout counter is $clog2(LOCKOUT+1) bits; repeat counter is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1) bits.

## Timing
- Reset values: pulse = 0, pulse_rpt = 0, busy = 0, FSM = IDLE, all counters 0, held record cleared.
- Press latency: with btn_n first sampled low at edge E0, pulse is high during the cycle after edge E(SYNC_STAGES).
- Lockout: busy rises in the same cycle as pulse and stays high for LOCKOUT cycles. The earliest next pulse is LOCKOUT+1 cycles after the previous one.
- First repeat: REPEAT_DELAY cycles after the press pulse, or later if the block is in lockout at that moment. Subsequent repeats follow every max(REPEAT_PERIOD, LOCKOUT+1) cycles.
- Reset asserted mid-lockout or mid-hold: all outputs drop asynchronously. No pulse is emitted in the cycle reset releases.

## Structure
- Package button_pkg:
  - State enum (IDLE, LOCK).
  - Function for a one-hot lowest-set-bit priority select.
  - Counter-width helper function.
- Sub-module btn_sync_edge: SYNC_STAGES synchroniser plus falling-edge detector, one instance per channel via generate. Outputs the synchronised level and the press request.
- Top level holds the arbiter, FSM, lockout counter and repeat tracker.

## Test plan
All scenarios use N_CH=3, SYNC_STAGES=2, LOCKOUT=15, REPEAT_DELAY=40, REPEAT_PERIOD=10, REPEAT_MASK=3'b011.
- Single tap: drive btn_n[1] low at cycle 0 and hold it for 5 cycles → pulse = 3'b010 in cycle 3 only; busy high in cycles 3–17; pulse_rpt = 0.
- Simultaneous press: drive btn_n[0] and btn_n[2] low in the same cycle → only pulse = 3'b001; channel 2's request is lost.
- Bounce within lockout: drive btn_n[0] low, toggle it 4 times within 10 cycles, then hold it high → exactly one pulse; pulse stays 0 for the rest of the lockout.
- Auto-repeat: with rpt_en = 1, hold btn_n[0] low for 100 cycles → the press pulse at cycle 3 is followed by repeats with pulse_rpt = 1 at cycles 43, 59, 75 and 91 (LOCKOUT-limited spacing of 16). Holding btn_n[2] instead gives no repeats (mask bit clear).
- Repeat preemption: while channel 0 repeats, tap btn_n[1] → pulse = 3'b010 with pulse_rpt = 0, and repeats of channel 0 stop.
- Reset during lockout: assert rst low at cycle 8 of busy → pulse = 0 and busy = 0 immediately. After release with btn_n[0] still low → one pulse = 3'b001 after 3 cycles.
